// File: rtl/obi_scratchpad_responder_if.sv
// OBI request/response bundle between an initiator and the scratchpad responder.
// Valid/ready rule: a request transfers on any rising edge where req_i && gnt_o; responses have no backpressure.
interface obi_scratchpad_responder_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/obi_scratchpad_responder.sv
// OBI responder backed by a word-addressed scratchpad; responses return in order
// after a fixed LATENCY through a shift pipeline, with bounded outstanding transactions.
module obi_scratchpad_responder #(
  parameter int NUM_WORDS       = 256,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  obi_scratchpad_responder_if.slave   bus,
  input  logic                        stall_i,
  output logic                        busy_o
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      mem [NUM_WORDS];
  logic [CNT_W-1:0] out_cnt;
  logic             pipe_v [LATENCY];
  logic             pipe_e [LATENCY];
  logic [31:0]      pipe_d [LATENCY];

  logic             hs;
  logic             in_range;
  logic             slot_free;
  logic [IDX_W-1:0] idx;
  logic             resp_err;
  logic [31:0]      resp_data;

  assign idx      = bus.addr_i[IDX_W+1:2];
  assign in_range = (bus.addr_i[31:IDX_W+2] == '0);

  // A response leaving this cycle frees its slot, so a full counter can still
  // grant; this is what lets MAX_OUTSTANDING == LATENCY sustain one per cycle.
  assign slot_free = (out_cnt < MAX_CNT) | pipe_v[LATENCY-1];
  assign bus.gnt_o = bus.req_i & ~stall_i & slot_free;
  assign hs        = bus.req_i & bus.gnt_o;

  always_comb begin
    resp_err  = ~in_range;
    resp_data = '0;
    if (!bus.we_i) begin
      resp_data = in_range ? mem[idx] : 32'hBADC_AB1E;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (hs && bus.we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.be_i[k]) begin
          mem[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_e[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= hs;
      pipe_e[0] <= hs & resp_err;
      pipe_d[0] <= hs ? resp_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt <= '0;
    end else begin
      case ({hs, pipe_v[LATENCY-1]})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  assign bus.rvalid_o = pipe_v[LATENCY-1];
  assign bus.err_o    = pipe_e[LATENCY-1];
  assign bus.rdata_o  = pipe_d[LATENCY-1];
  assign busy_o       = (out_cnt != '0);
endmodule

// File: tb/tb_obi_scratchpad_responder.sv
// Bench for obi_scratchpad_responder: a LATENCY=1 instance (A) and a LATENCY=3 /
// MAX_OUTSTANDING=2 instance (B) share one driver, each with its own expected queue.
module tb_obi_scratchpad_responder;
  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared driver state; sel picks which instance sees req
  logic        req, we, stall, sel, stall_rand;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, busy_a, busy_b;

  obi_scratchpad_responder_if if_a ();
  obi_scratchpad_responder_if if_b ();

  assign if_a.req_i   = req & ~sel;
  assign if_a.addr_i  = addr;
  assign if_a.we_i    = we;
  assign if_a.be_i    = be;
  assign if_a.wdata_i = wdata;
  assign if_b.req_i   = req & sel;
  assign if_b.addr_i  = addr;
  assign if_b.we_i    = we;
  assign if_b.be_i    = be;
  assign if_b.wdata_i = wdata;
  assign gnt = sel ? if_b.gnt_o : if_a.gnt_o;

  obi_scratchpad_responder #(.NUM_WORDS(256), .LATENCY(1), .MAX_OUTSTANDING(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .bus(if_a.slave), .stall_i(stall), .busy_o(busy_a)
  );
  obi_scratchpad_responder #(.NUM_WORDS(256), .LATENCY(3), .MAX_OUTSTANDING(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .bus(if_b.slave), .stall_i(stall), .busy_o(busy_b)
  );

  // scoreboard: {err, rdata}
  logic [32:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [32:0] got, logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst && if_a.rvalid_o) begin
      if (exp_q_a.size() == 0) begin
        n_checks++;
        $display("FAIL resp_a unexpected rvalid err=%b rdata=%h exp=none", if_a.err_o, if_a.rdata_o);
      end else check("resp_a", {if_a.err_o, if_a.rdata_o}, exp_q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && if_b.rvalid_o) begin
      if (exp_q_b.size() == 0) begin
        n_checks++;
        $display("FAIL resp_b unexpected rvalid err=%b rdata=%h exp=none", if_b.err_o, if_b.rdata_o);
      end else check("resp_b", {if_b.err_o, if_b.rdata_o}, exp_q_b.pop_front());
    end
  end

  // driver tasks: called just after a falling edge, return just after one
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [32:0] exp);
    bit done = 1'b0;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    for (int n = 0; n < 64 && !done; n++) begin
      stall = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (gnt) begin
        if (sel) exp_q_b.push_back(exp);
        else     exp_q_a.push_back(exp);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_checks++;
      $display("FAIL grant_timeout addr=%h got=no_gnt exp=gnt", a);
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0; stall = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [10:0] gpat, vpat;
  bit          busy_ok, saw_rvalid;
  int          granted;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; stall = 1'b0; sel = 1'b0; stall_rand = 1'b0;
    addr = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rvalid_a", 33'(if_a.rvalid_o), 33'd0);
    check("rst_busy_b", 33'(busy_b), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: idle, then a lone request is granted combinationally
    #1;
    check("idle_gnt", 33'(gnt), 33'd0);
    check("idle_rvalid", 33'({if_a.rvalid_o, if_b.rvalid_o}), 33'd0);
    check("idle_busy", 33'({busy_a, busy_b}), 33'd0);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0;
    #1;
    check("gnt_same_cycle", 33'(gnt), 33'd1);
    if (gnt) exp_q_a.push_back(33'h0);
    @(negedge clk);
    idle(3);

    // 2: back-to-back write then read, LATENCY=1
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, {1'b0, 32'h0});
    issue(1'b0, 32'h10, 4'h0, 32'h0,       {1'b0, 32'hDEADBEEF});
    // 3: partial write
    issue(1'b1, 32'h20, 4'hF,    32'h11223344, {1'b0, 32'h0});
    issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, {1'b0, 32'h0});
    issue(1'b0, 32'h20, 4'h0,    32'h0,        {1'b0, 32'h11BB33DD});
    // 5: out of range on A; write must not alias onto word 0
    issue(1'b0, 32'h400,      4'h0, 32'h0,        {1'b1, 32'hBADCAB1E});
    issue(1'b1, 32'h400,      4'hF, 32'hFFFFFFFF, {1'b1, 32'h0});
    issue(1'b0, 32'h8000_0010, 4'h0, 32'h0,       {1'b1, 32'hBADCAB1E});
    issue(1'b0, 32'h0,        4'h0, 32'h0,        {1'b0, 32'h0});
    issue(1'b0, 32'h10,       4'h0, 32'h0,        {1'b0, 32'hDEADBEEF});
    issue(1'b1, 32'h3FC,      4'hF, 32'h600DF00D, {1'b0, 32'h0});
    issue(1'b0, 32'h3FC,      4'h0, 32'h0,        {1'b0, 32'h600DF00D});
    idle(4);

    // 4: LATENCY=3, MAX_OUTSTANDING=2, six held reads
    sel = 1'b1;
    issue(1'b1, 32'h40, 4'hF, 32'hCAFE0040, {1'b0, 32'h0});
    idle(6);
    req = 1'b1; we = 1'b0; addr = 32'h40; be = 4'h0;
    gpat = '0; vpat = '0; busy_ok = 1'b1; granted = 0;
    for (int c = 0; c < 11; c++) begin
      #1;
      gpat[c] = gnt;
      vpat[c] = if_b.rvalid_o;
      if (c > 0 && !busy_b) busy_ok = 1'b0;
      if (gnt) begin
        exp_q_b.push_back({1'b0, 32'hCAFE0040});
        granted++;
      end
      @(negedge clk);
      if (granted == 6) req = 1'b0;
    end
    check("gnt_pattern", 33'(gpat), 33'(11'b000_1101_1011));
    check("rvalid_pattern", 33'(vpat), 33'(11'b110_1101_1000));
    check("busy_throughout", 33'(busy_ok), 33'd1);
    idle(4);

    // 6: random stall on B, then reset with two reads in flight
    stall_rand = 1'b1;
    issue(1'b1, 32'h80, 4'hF, 32'h01010101, {1'b0, 32'h0});
    issue(1'b1, 32'h84, 4'hF, 32'h02020202, {1'b0, 32'h0});
    issue(1'b0, 32'h80, 4'h0, 32'h0,        {1'b0, 32'h01010101});
    issue(1'b1, 32'h88, 4'hC, 32'h0303FFFF, {1'b0, 32'h0});
    issue(1'b0, 32'h88, 4'h0, 32'h0,        {1'b0, 32'h03030000});
    issue(1'b0, 32'h84, 4'h0, 32'h0,        {1'b0, 32'h02020202});
    issue(1'b0, 32'h500, 4'h0, 32'h0,       {1'b1, 32'hBADCAB1E});
    issue(1'b0, 32'h40, 4'h0, 32'h0,        {1'b0, 32'hCAFE0040});
    stall_rand = 1'b0;
    idle(6);
    check("drained_busy_b", 33'(busy_b), 33'd0);
    issue(1'b0, 32'h80, 4'h0, 32'h0, {1'b0, 32'h01010101});
    issue(1'b0, 32'h84, 4'h0, 32'h0, {1'b0, 32'h02020202});
    req = 1'b0;
    rst = 1'b1;
    exp_q_a.delete();
    exp_q_b.delete();
    #1;
    check("reset_busy_b", 33'(busy_b), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_rvalid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (if_b.rvalid_o || if_a.rvalid_o) saw_rvalid = 1'b1;
      @(negedge clk);
    end
    check("no_rvalid_after_reset", 33'(saw_rvalid), 33'd0);
    issue(1'b0, 32'h80, 4'h0, 32'h0, {1'b0, 32'h0});
    issue(1'b0, 32'h40, 4'h0, 32'h0, {1'b0, 32'h0});
    sel = 1'b0;
    idle(1);
    issue(1'b0, 32'h10, 4'h0, 32'h0, {1'b0, 32'h0});
    idle(8);

    check("queue_a_empty", 33'(exp_q_a.size()), 33'd0);
    check("queue_b_empty", 33'(exp_q_b.size()), 33'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
